// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master single-port data memory arbiter with m1 lock; DMEM_ARB_RR_EN selects round-robin over fixed m0 priority
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_stall
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, LOCK1} state_t;
  state_t state;
  logic [4:0] cnt;
  logic rdy, pend0, pend1, en, lk, force0, pref1, g0, g1;
  assign en = reset & rdy;
  assign lk = (state == LOCK1) & m1_req & m1_lock;
  assign force0 = lk & m0_req & (cnt == 5'd16);
`ifdef DMEM_ARB_RR_EN
  assign pref1 = (state == OWN0);
`else
  assign pref1 = 1'b0;
`endif
  assign g1 = en & m1_req & (lk ? ~force0 : (~m0_req | pref1));
  assign g0 = en & m0_req & ~g1;
  assign m0_gnt = g0;
  assign m1_gnt = g1;
  assign mem_en = g0 | g1;
  assign mem_we = (g0 & m0_we) | (g1 & m1_we);
  assign mem_addr = g1 ? m1_addr : g0 ? m0_addr : '0;
  assign mem_wdata = g1 ? m1_wdata : g0 ? m0_wdata : '0;
  assign m0_rvalid = pend0 & reset;
  assign m1_rvalid = pend1 & reset;
  assign m0_rdata = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata = m1_rvalid ? mem_rdata : '0;
  assign cpu_stall = m0_req & ~g0;
  // owner tracking, lock bound counter and pending read responses
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rdy <= 1'b0;
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      rdy <= 1'b1;
      pend0 <= g0 & ~m0_we;
      pend1 <= g1 & ~m1_we;
      if (g0) begin
        state <= OWN0;
        cnt <= '0;
      end else if (g1) begin
        state <= m1_lock ? LOCK1 : OWN1;
        cnt <= !m1_lock ? '0 : m0_req ? cnt + 5'd1 : cnt;
      end else if (state == LOCK1 && !lk) begin
        state <= OWN1;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector and sequence checks for dmem_arbiter
module tb_dmem_arbiter;
  localparam bit O = 1'b0;
  localparam bit I = 1'b1;
  logic clk, reset;
  logic m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic mem_en, mem_we, cpu_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] bmem [256];
  int checks = 0;
  int errors = 0;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    logic rn, r0, w0;
    logic [31:0] a0, d0;
    logic r1, w1, l1;
    logic [31:0] a1, d1;
    logic eg0, eg1, erv0, erv1;
    logic [31:0] erd0, erd1;
    logic est;
  } vec_t;
  vec_t vt [14];

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural single-port memory, one cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bmem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= bmem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic rn, r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, l1, input logic [31:0] a1, d1);
    reset = rn; m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string n, input logic e0, input logic e1);
    @(negedge clk);
    chk({n, "_gnt0"}, m0_gnt, e0);
    chk({n, "_gnt1"}, m1_gnt, e1);
    chk({n, "_men"}, mem_en, e0 | e1);
    chk({n, "_stall"}, cpu_stall, m0_req & ~e0);
  endtask

  initial begin
    vt = '{
      '{O, I,O,32'h10,32'h0,        I,I,O,32'h10,32'hDEADBEEF, O,O,O,O,32'h0,32'h0,I},
      '{O, I,O,32'h10,32'h0,        I,I,O,32'h10,32'hDEADBEEF, O,O,O,O,32'h0,32'h0,I},
      '{I, I,O,32'h10,32'h0,        I,I,O,32'h10,32'hDEADBEEF, O,O,O,O,32'h0,32'h0,I},
      '{I, O,O,32'h0,32'h0,         I,I,O,32'h10,32'hDEADBEEF, O,I,O,O,32'h0,32'h0,O},
      '{I, I,O,32'h10,32'h0,        O,O,O,32'h0,32'h0,         I,O,O,O,32'h0,32'h0,O},
      '{I, O,O,32'h0,32'h0,         O,O,O,32'h0,32'h0,         O,O,I,O,32'hDEADBEEF,32'h0,O},
      '{I, O,O,32'h0,32'h0,         I,I,O,32'h20,32'h55,       O,I,O,O,32'h0,32'h0,O},
      '{I, I,O,32'h20,32'h0,        O,O,O,32'h0,32'h0,         I,O,O,O,32'h0,32'h0,O},
      '{I, O,O,32'h0,32'h0,         O,O,O,32'h0,32'h0,         O,O,I,O,32'h55,32'h0,O},
      '{I, O,O,32'h0,32'h0,         I,O,O,32'h10,32'h0,        O,I,O,O,32'h0,32'h0,O},
      '{I, O,O,32'h0,32'h0,         O,O,O,32'h0,32'h0,         O,O,O,I,32'h0,32'hDEADBEEF,O},
      '{I, I,I,32'h30,32'h1234,     I,O,O,32'h30,32'h0,        I,O,O,O,32'h0,32'h0,O},
      '{I, O,O,32'h0,32'h0,         I,O,O,32'h30,32'h0,        O,I,O,O,32'h0,32'h0,O},
      '{I, O,O,32'h0,32'h0,         O,O,O,32'h0,32'h0,         O,O,O,I,32'h0,32'h1234,O}
    };
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].rn, vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0,
            vt[i].r1, vt[i].w1, vt[i].l1, vt[i].a1, vt[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), m0_gnt, vt[i].eg0);
      chk($sformatf("v%0d_gnt1", i), m1_gnt, vt[i].eg1);
      chk($sformatf("v%0d_men", i), mem_en, vt[i].eg0 | vt[i].eg1);
      chk($sformatf("v%0d_rv0", i), m0_rvalid, vt[i].erv0);
      chk($sformatf("v%0d_rv1", i), m1_rvalid, vt[i].erv1);
      chk($sformatf("v%0d_rd0", i), m0_rdata, vt[i].erd0);
      chk($sformatf("v%0d_rd1", i), m1_rdata, vt[i].erd1);
      chk($sformatf("v%0d_stall", i), cpu_stall, vt[i].est);
      next_cycle();
    end
    // contention from OWN1: alternating when round-robin, m0 always otherwise
    for (int i = 0; i < 6; i++) begin
      drive(I, I,O,32'h10,32'h0, I,O,O,32'h20,32'h0);
      chk_gnt($sformatf("both%0d", i), RR ? (i % 2 == 0) : I, RR ? (i % 2 == 1) : O);
      next_cycle();
    end
    // lock entry by m1 alone, then 16 locked grants against m0 before m0 is forced in
    drive(I, O,O,32'h0,32'h0, I,O,I,32'h20,32'h0);
    chk_gnt("lock_in", O, I);
    next_cycle();
    for (int i = 0; i < 17; i++) begin
      drive(I, I,O,32'h10,32'h0, I,O,I,32'h20,32'h0);
      chk_gnt($sformatf("lock%0d", i), i == 16, i < 16);
      next_cycle();
    end
    drive(I, I,O,32'h10,32'h0, I,O,O,32'h20,32'h0);
    chk_gnt("after_bound", ~RR, RR);
    next_cycle();
    // lock release arbitrates from OWN1, so m0 wins
    drive(I, O,O,32'h0,32'h0, I,O,I,32'h20,32'h0);
    chk_gnt("relock", O, I);
    next_cycle();
    drive(I, I,O,32'h10,32'h0, I,O,I,32'h20,32'h0);
    chk_gnt("locked", O, I);
    next_cycle();
    drive(I, I,O,32'h10,32'h0, I,O,O,32'h20,32'h0);
    chk_gnt("unlock", I, O);
    next_cycle();
    // reset one cycle after a granted read suppresses the response
    drive(I, I,O,32'h10,32'h0, O,O,O,32'h0,32'h0);
    chk_gnt("pre_rst", I, O);
    next_cycle();
    drive(O, O,O,32'h0,32'h0, O,O,O,32'h0,32'h0);
    @(negedge clk);
    chk("rst_rv0", m0_rvalid, O);
    chk("rst_rd0", m0_rdata, 32'h0);
    chk("rst_men", mem_en, O);
    next_cycle();
    drive(I, I,O,32'h10,32'h0, O,O,O,32'h0,32'h0);
    @(negedge clk);
    chk("post_rst_rv0", m0_rvalid, O);
    chk("post_rst_gnt0", m0_gnt, O);
    chk("post_rst_men", mem_en, O);
    chk("post_rst_stall", cpu_stall, I);
    next_cycle();
    chk_gnt("resume", I, O);
    next_cycle();
    drive(I, O,O,32'h0,32'h0, O,O,O,32'h0,32'h0);
    @(negedge clk);
    chk("resume_rv0", m0_rvalid, I);
    chk("resume_rd0", m0_rdata, 32'hDEADBEEF);
    chk("resume_rv1", m1_rvalid, O);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
